// File: rtl/ad9228_link_trainer.sv
// ad9228_link_trainer: per-channel SERDES reset, cadence lock and test-pattern training
// for the AD9228 receive path, with automatic retrain on loss of lock.
module ad9228_link_trainer #(
    parameter int DATA_WIDTH     = 12,
    parameter int RST_CYCLES     = 16,
    parameter int SETTLE_CYCLES  = 64,
    parameter int LOCK_WINDOWS   = 8,
    parameter int PATTERN_WORDS  = 32,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MAX_RETRIES    = 7
) (
    input  logic                  dco_div4,
    input  logic                  rst,
    input  logic                  start_train,
    input  logic [DATA_WIDTH-1:0] des_data,
    input  logic                  des_data_valid,
    input  logic [DATA_WIDTH-1:0] test_pattern,
    output logic                  serdes_rst,
    output logic                  test_mode_req,
    output logic                  link_ready,
    output logic                  train_fail,
    output logic [2:0]            retry_count,
    output logic [7:0]            relock_count,
    output logic [2:0]            state_dbg
);
    typedef enum logic [2:0] {IDLE, SRST, SETTLE, LOCK, PATTERN, READY, FAIL} state_t;

    localparam int CW = $clog2((RST_CYCLES > SETTLE_CYCLES ? RST_CYCLES : SETTLE_CYCLES) + 1);
    localparam int GW = $clog2(LOCK_WINDOWS + 1);
    localparam int MW = $clog2(PATTERN_WORDS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state, nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    wph, vcnt;
    logic [GW-1:0] gcnt;
    logic [MW-1:0] mcnt;
    logic [TW-1:0] tcnt;
    logic          bad_seen;
    logic          active, wend, wgood, wbad, mism, timeout, fail_evt, lol;

    // 8->12 gearbox: every 3-cycle window must carry exactly two valid words
    assign active    = state inside {LOCK, PATTERN, READY};
    assign wend      = active && wph == 2'd2;
    assign wgood     = (vcnt + 2'(des_data_valid)) == 2'd2;
    assign wbad      = wend && !wgood;
    assign mism      = des_data_valid && des_data != test_pattern;
    assign timeout   = tcnt == TW'(TIMEOUT_CYCLES - 1);
    assign fail_evt  = (state == LOCK && timeout) || (state == PATTERN && (timeout || mism || wbad));
    assign lol       = state == READY && wbad && bad_seen;
    assign state_dbg = state;

    always_comb begin
        nxt = state;
        if (start_train) nxt = SRST;
        else if (fail_evt) nxt = (retry_count == 3'(MAX_RETRIES)) ? FAIL : SRST;
        else if (lol) nxt = SRST;
        else case (state)
            SRST:    if (cnt == CW'(RST_CYCLES - 1)) nxt = SETTLE;
            SETTLE:  if (cnt == CW'(SETTLE_CYCLES - 1)) nxt = LOCK;
            LOCK:    if (wend && wgood && gcnt == GW'(LOCK_WINDOWS - 1)) nxt = PATTERN;
            PATTERN: if (des_data_valid && mcnt == MW'(PATTERN_WORDS - 1)) nxt = READY;
            default: ;
        endcase
    end

    always_ff @(posedge dco_div4 or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            serdes_rst    <= 1'b1;
            test_mode_req <= 1'b0;
            link_ready    <= 1'b0;
            train_fail    <= 1'b0;
            retry_count   <= 3'd0;
            relock_count  <= 8'd0;
            cnt           <= '0;
            wph           <= 2'd0;
            vcnt          <= 2'd0;
            gcnt          <= '0;
            mcnt          <= '0;
            tcnt          <= '0;
            bad_seen      <= 1'b0;
        end else begin
            state         <= nxt;
            serdes_rst    <= nxt inside {IDLE, SRST, FAIL};
            test_mode_req <= nxt inside {SRST, SETTLE, LOCK, PATTERN};
            link_ready    <= nxt == READY;
            train_fail    <= nxt == FAIL;
            retry_count   <= (start_train || lol) ? 3'd0 :
                             (fail_evt && nxt == SRST) ? retry_count + 3'd1 : retry_count;
            relock_count  <= (lol && !start_train && relock_count != 8'hFF) ? relock_count + 8'd1 : relock_count;
            cnt           <= (nxt == state && !start_train && state inside {SRST, SETTLE}) ? cnt + CW'(1) : '0;
            wph           <= (active && !wend) ? wph + 2'd1 : 2'd0;
            vcnt          <= (active && !wend) ? vcnt + 2'(des_data_valid) : 2'd0;
            gcnt          <= (state != LOCK) ? '0 : wend ? (wgood ? gcnt + GW'(1) : '0) : gcnt;
            mcnt          <= (state == PATTERN) ? mcnt + MW'(des_data_valid && !mism) : '0;
            tcnt          <= (state inside {LOCK, PATTERN}) ? tcnt + TW'(1) : '0;
            bad_seen      <= (state != READY) ? 1'b0 : wend ? wbad : bad_seen;
        end
    end
endmodule

// File: doc/ad9228_link_trainer.md
Name: ad9228_link_trainer

Overview:
- Per-channel link-training controller for the AD9228 SERDES/gearbox receive path, clocked in the dco_div4 domain.
- Sequences the ISERDES/gearbox reset and qualifies frame cadence from des_data_valid.
- Checks deserialized words against the ADC test pattern, then asserts link_ready.
- Watches cadence while ready and retrains automatically on loss of lock.

Parameters:
- DATA_WIDTH, 12, deserialized word width.
- RST_CYCLES, 16, cycles serdes_rst is held high per attempt (≥1).
- SETTLE_CYCLES, 64, cycles waited after serdes_rst drops before cadence checking starts.
- LOCK_WINDOWS, 8, consecutive good 3-cycle windows required for cadence lock.
- PATTERN_WORDS, 32, consecutive matching valid words required to pass pattern check.
- TIMEOUT_CYCLES, 4096, maximum cycles spent in LOCK plus PATTERN per attempt.
- MAX_RETRIES, 7, failed attempts tolerated before FAIL.

Ports:
- dco_div4, input, 1: block clock.
- rst, input, 1: asynchronous active-high reset.
- start_train, input, 1: single-cycle pulse that starts or restarts training.
- des_data, input, DATA_WIDTH: gearbox output word.
- des_data_valid, input, 1: gearbox word strobe.
- test_pattern, input, DATA_WIDTH: expected ADC test-mode word; quasi-static.
- serdes_rst, output, 1: active-high reset to ISERDES and gearbox.
- test_mode_req, output, 1: requests the ADC to output test_pattern (consumed by SPI config logic).
- link_ready, output, 1: link trained and in lock.
- train_fail, output, 1: retries exhausted; sticky until start_train or rst.
- retry_count, output, 3: failed attempts in the current training run.
- relock_count, output, 8: losses of lock since rst; saturates at 255.
- state_dbg, output, 3: current state encoding.

Behaviour:
- Reset values: serdes_rst=1, test_mode_req=0, link_ready=0, train_fail=0, retry_count=0, relock_count=0, state=IDLE.
- States and encodings: IDLE(0), SRST(1), SETTLE(2), LOCK(3), PATTERN(4), READY(5), FAIL(6). All outputs are registered.
- IDLE: serdes_rst=1. On start_train: go to SRST, set retry_count=0, clear train_fail.
- SRST:
  - serdes_rst=1, test_mode_req=1.
  - Stay exactly RST_CYCLES cycles, then go to SETTLE.
- SETTLE:
  - serdes_rst=0, test_mode_req=1.
  - Stay SETTLE_CYCLES cycles, then go to LOCK.
  - Clear the window counter, good-window counter, match counter and timeout counter on entry.
- LOCK (cadence check):
  - Partition cycles into 3-cycle windows.
  - A window is good if des_data_valid was high in exactly 2 of its 3 cycles (8→12 gearbox ratio).
  - Good window: increment the good counter. Bad window: clear it.
  - When the good counter reaches LOCK_WINDOWS, go to PATTERN.
- PATTERN:
  - On each valid word, compare des_data with test_pattern.
  - Match increments the match counter.
  - Any mismatch, or a bad 3-cycle window, is a failed attempt.
  - When the match counter reaches PATTERN_WORDS, go to READY.
- Timeout: a timer counts every cycle in LOCK and PATTERN. Reaching TIMEOUT_CYCLES is a failed attempt.
- Failed attempt:
  - If retry_count == MAX_RETRIES, go to FAIL.
  - Otherwise increment retry_count and go to SRST.
- READY:
  - link_ready=1, test_mode_req=0, serdes_rst=0.
  - Cadence windows keep being checked; data content is ignored.
  - Two consecutive bad windows = loss of lock. On loss of lock: link_ready drops the next cycle, relock_count increments (saturating), retry_count clears, go to SRST.
- FAIL: train_fail=1, serdes_rst=1, test_mode_req=0. Stay until start_train.
- start_train in any state except IDLE restarts at SRST with retry_count=0. link_ready and train_fail clear the next cycle.
- start_train coinciding with a failed-attempt or loss-of-lock event: start_train wins, and relock_count is not incremented.
- rst asserted mid-operation forces all reset values immediately, including relock_count=0.
- Counter widths must cover their parameter values. Counters never wrap; they saturate or clear as stated above.

Test Plan:
- Deassert rst, pulse start_train, drive an ideal valid cadence (1,1,0 repeating) and des_data=test_pattern=12'hA5C:
  - serdes_rst stays high for 16 cycles, then link_ready asserts.
  - retry_count=0, test_mode_req drops with link_ready.
- Same stimulus, but corrupt one PATTERN word (12'hA5D) on the first attempt only: retry_count=1, second attempt reaches READY.
- des_data_valid stuck low: each attempt times out at 4096 cycles; after 8 attempts train_fail=1, state_dbg=6, retry_count=7.
- In READY, insert one bad window: stays READY. Insert two consecutive bad windows: link_ready=0 the next cycle, relock_count=1, serdes_rst pulses for 16 cycles, link_ready re-asserts.
- Pulse start_train mid-PATTERN: immediate return to SRST, retry_count=0, no relock_count change.
- Assert rst asynchronously mid-LOCK: all outputs are at reset values before the next clock edge.
